// File: rtl/macro_decoder_bin_onehot_pkg.sv
// Shared state encoding and width helper for the buffered binary-to-one-hot decoder.
package macro_decoder_bin_onehot_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic int onehot_width(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/macro_decoder_bin_onehot_comb.sv
// Pure binary-to-one-hot decode; all-zero output when the enable is low.
module macro_decoder_bin_onehot_comb
  import macro_decoder_bin_onehot_pkg::*;
#(
  parameter int INPUT_WIDTH = 2
) (
  input  logic [INPUT_WIDTH-1:0]               i_d,
  input  logic                                 i_en,
  output logic [onehot_width(INPUT_WIDTH)-1:0] o_q
);

  localparam int OW = onehot_width(INPUT_WIDTH);

  always_comb begin
    o_q = '0;
    for (int k = 0; k < OW; k++) begin
      o_q[k] = i_en && (i_d == INPUT_WIDTH'(k));
    end
  end

endmodule

// File: rtl/macro_encoder_onehot_bin.sv
// One-hot to binary encoder (inverse of the decoder macro); OR-combines indices of set bits.
module macro_encoder_onehot_bin #(
  parameter int WIDTH = 2
) (
  input  logic [(1<<WIDTH)-1:0] i_onehot,
  output logic [WIDTH-1:0]      o_bin
);

  always_comb begin
    o_bin = '0;
    for (int k = 0; k < (1 << WIDTH); k++) begin
      if (i_onehot[k]) o_bin = o_bin | WIDTH'(k);
    end
  end

endmodule

// File: rtl/macro_decoder_bin_onehot_buffered.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer (valid/ready both sides).
// Optional integrity checker enabled by defining MACRO_DECODER_BIN_ONEHOT_CHECK_EN (adds o_chk_err).
module macro_decoder_bin_onehot_buffered
  import macro_decoder_bin_onehot_pkg::*;
#(
  parameter int INPUT_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 i_valid,
  output logic                                 i_ready,
  input  logic [INPUT_WIDTH-1:0]               i_d,
  input  logic                                 i_en,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [onehot_width(INPUT_WIDTH)-1:0] o_q
`ifdef MACRO_DECODER_BIN_ONEHOT_CHECK_EN
  ,
  output logic                                 o_chk_err
`endif
);

  localparam int OW = onehot_width(INPUT_WIDTH);

  state_e          state_q, state_d;
  logic [OW-1:0]   main_q, main_d;
  logic [OW-1:0]   skid_q, skid_d;
  logic [OW-1:0]   dec_word;
  logic            in_fire, out_fire;
  logic            ld_main_in, ld_skid_in, mv_skid, clr_main;

  macro_decoder_bin_onehot_comb #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_dec (
    .i_d (i_d),
    .i_en(i_en),
    .o_q (dec_word)
  );

  // Both handshake outputs come straight from the state register.
  assign i_ready  = (state_q != ST_FULL);
  assign o_valid  = (state_q != ST_EMPTY);
  assign o_q      = main_q;
  assign in_fire  = i_valid && i_ready;
  assign out_fire = o_valid && o_ready;

  always_comb begin
    state_d    = state_q;
    ld_main_in = 1'b0;
    ld_skid_in = 1'b0;
    mv_skid    = 1'b0;
    clr_main   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid_in = 1'b1;
          state_d    = ST_FULL;
        end else if (out_fire) begin
          clr_main = 1'b1;
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          mv_skid = 1'b1;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (ld_main_in) main_d = dec_word;
    if (clr_main)   main_d = '0;
    if (ld_skid_in) skid_d = dec_word;
    if (mv_skid) begin
      main_d = skid_q;
      skid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MACRO_DECODER_BIN_ONEHOT_CHECK_EN
  // Shadow holds {enable, index} for each entry and follows its decoded word.
  logic [INPUT_WIDTH:0]   main_sh_q, main_sh_d;
  logic [INPUT_WIDTH:0]   skid_sh_q, skid_sh_d;
  logic [INPUT_WIDTH-1:0] enc_bin;
  logic [INPUT_WIDTH:0]   pop_cnt;
  logic                   mismatch;
  logic                   chk_err_q;

  function automatic logic [INPUT_WIDTH:0] popcount(input logic [OW-1:0] v);
    logic [INPUT_WIDTH:0] cnt;
    cnt = '0;
    for (int k = 0; k < OW; k++) begin
      cnt = cnt + {{INPUT_WIDTH{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  macro_encoder_onehot_bin #(
    .WIDTH(INPUT_WIDTH)
  ) u_enc (
    .i_onehot(main_q),
    .o_bin   (enc_bin)
  );

  always_comb begin
    main_sh_d = main_sh_q;
    skid_sh_d = skid_sh_q;
    if (ld_main_in) main_sh_d = {i_en, i_d};
    if (clr_main)   main_sh_d = '0;
    if (ld_skid_in) skid_sh_d = {i_en, i_d};
    if (mv_skid) begin
      main_sh_d = skid_sh_q;
      skid_sh_d = '0;
    end
  end

  always_comb begin
    pop_cnt = popcount(main_q);
    if (main_sh_q[INPUT_WIDTH]) begin
      mismatch = (pop_cnt != (INPUT_WIDTH+1)'(1)) || (enc_bin != main_sh_q[INPUT_WIDTH-1:0]);
    end else begin
      mismatch = (pop_cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_sh_q <= '0;
      skid_sh_q <= '0;
      chk_err_q <= 1'b0;
    end else begin
      main_sh_q <= main_sh_d;
      skid_sh_q <= skid_sh_d;
      chk_err_q <= chk_err_q || (o_valid && mismatch);
    end
  end

  assign o_chk_err = chk_err_q;
`endif

endmodule
